// File: rtl/thermo_pkg.sv
// Shared types and helpers for the thermometer pattern generator.
//   state_e    : generator FSM state (IDLE / SINGLE / SWEEP), built on the
//                S_* localparam encodings so older code can keep using them.
//   mode_e     : request mode field encodings 0..3 (3 is reserved and
//                behaves like SINGLE).
//   sat_count  : clamps a requested count to the word width.
package thermo_pkg;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SINGLE = 2'd1;
  localparam logic [1:0] S_SWEEP  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE   = S_IDLE,
    ST_SINGLE = S_SINGLE,
    ST_SWEEP  = S_SWEEP
  } state_e;

  typedef enum logic [1:0] {
    MODE_SINGLE   = 2'd0,
    MODE_SWEEP_UP = 2'd1,
    MODE_SWEEP_DN = 2'd2,
    MODE_RSVD     = 2'd3
  } mode_e;

  // Requests larger than the word width produce an all-ones word.
  function automatic int unsigned sat_count(input int unsigned k, input int unsigned n);
    return (k > n) ? n : k;
  endfunction

endpackage

// File: rtl/therm_encode.sv
// Combinational count -> thermometer encoder.
//   count  [CW-1:0] : number of low bits to set (0..N)
//   bubble          : when set and count >= 2, bit count-2 is cleared so
//                     the word has popcount count-1 (one interior hole)
//   x      [N-1:0]  : thermometer word, bit i = (i < count)
module therm_encode
  import thermo_pkg::*;
#(
  parameter int N  = 64,
  parameter int CW = $clog2(N) + 1
) (
  input  logic [CW-1:0] count,
  input  logic          bubble,
  output logic [N-1:0]  x
);

  always_comb begin
    x = '0;
    for (int i = 0; i < N; i++) begin
      // The hole sits one below the top set bit, so the word still looks
      // like a delay-line capture with a single metastable tap.
      x[i] = (i < int'(count)) &&
             !(bubble && (int'(count) >= 2) && (i == int'(count) - 2));
    end
  end

endmodule

// File: rtl/thermo_pattern_gen.sv
// Thermometer-code pattern generator feeding the pop-count self-test path.
// Emits a single thermometer word (optionally with one bubble) or a sweep of
// all counts 0..N / N..0, one word per enabled cycle.
//
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   en              : advance enable; low freezes everything, val_out/done drop
//   start           : request pulse, accepted only in IDLE with en=1
//   mode [1:0]      : 0 SINGLE, 1 SWEEP_UP, 2 SWEEP_DN, 3 treated as SINGLE
//   count_in [CW-1:0]: SINGLE count, clamped to N
//   bubble_in       : inject one bubble into a SINGLE word (k >= 2)
//   x_out [N-1:0]   : thermometer word
//   val_out         : x_out carries a new word this cycle
//   busy            : FSM not in IDLE
//   done            : last word of the operation (coincides with val_out)
//   dbg_state [1:0] : current FSM state for observation
//
// Handshake: val_out is a one-cycle valid with no back-pressure; every cycle
// with val_out=1 is exactly one word for the consumer, and the word stays on
// x_out until the next one is emitted. All outputs come straight from flops.
module thermo_pattern_gen
  import thermo_pkg::*;
#(
  parameter int N  = 64,
  parameter int CW = $clog2(N) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          start,
  input  logic [1:0]    mode,
  input  logic [CW-1:0] count_in,
  input  logic          bubble_in,
  output logic [N-1:0]  x_out,
  output logic          val_out,
  output logic          busy,
  output logic          done,
  output logic [1:0]    dbg_state
);

  localparam logic [CW-1:0] K_MAX = CW'(N);
  localparam logic [CW-1:0] K_ONE = CW'(1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;   // k of the word currently on x_out
  logic          dn_q, dn_d;     // sweep direction: 1 = counting down
  logic [N-1:0]  x_q, x_d;
  logic          val_q, val_d;
  logic          done_q, done_d;

  mode_e         mode_sel;
  logic          is_sweep;
  logic [CW-1:0] sat_k;
  logic [CW-1:0] term_k;
  logic [CW-1:0] enc_k;
  logic          enc_bubble;
  logic [N-1:0]  enc_x;

  assign mode_sel = mode_e'(mode);
  assign is_sweep = (mode_sel == MODE_SWEEP_UP) || (mode_sel == MODE_SWEEP_DN);
  assign sat_k    = CW'(sat_count(32'(count_in), N));
  assign term_k   = dn_q ? '0 : K_MAX;

  // Count for the word that would be emitted at the next edge. In IDLE it
  // comes from the request; in SWEEP it is the neighbour of the current k.
  // The underflow/overflow value at the sweep end is never used because the
  // terminal compare below stops the sweep first.
  always_comb begin
    enc_k      = cnt_q;
    enc_bubble = 1'b0;
    if (state_q == ST_IDLE) begin
      if (is_sweep) begin
        enc_k = (mode_sel == MODE_SWEEP_DN) ? K_MAX : '0;
      end else begin
        enc_k      = sat_k;
        enc_bubble = bubble_in;
      end
    end else if (dn_q) begin
      enc_k = cnt_q - K_ONE;
    end else begin
      enc_k = cnt_q + K_ONE;
    end
  end

  therm_encode #(
    .N (N),
    .CW(CW)
  ) u_encode (
    .count (enc_k),
    .bubble(enc_bubble),
    .x     (enc_x)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dn_d    = dn_q;
    x_d     = x_q;
    val_d   = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (en && start) begin
          cnt_d = enc_k;
          x_d   = enc_x;
          val_d = 1'b1;
          if (is_sweep) begin
            state_d = ST_SWEEP;
            dn_d    = (mode_sel == MODE_SWEEP_DN);
          end else begin
            state_d = ST_SINGLE;
            done_d  = 1'b1;
          end
        end
      end
      ST_SINGLE: begin
        // The word was issued on entry; leave once the consumer has had it.
        if (en) begin
          state_d = ST_IDLE;
        end
      end
      ST_SWEEP: begin
        if (en) begin
          // Compare before stepping so the counter never wraps past N or 0.
          if (cnt_q == term_k) begin
            state_d = ST_IDLE;
          end else begin
            cnt_d  = enc_k;
            x_d    = enc_x;
            val_d  = 1'b1;
            done_d = (enc_k == term_k);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      dn_q    <= 1'b0;
      x_q     <= '0;
      val_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dn_q    <= dn_d;
      x_q     <= x_d;
      val_q   <= val_d;
      done_q  <= done_d;
    end
  end

  assign x_out     = x_q;
  assign val_out   = val_q;
  assign done      = done_q;
  assign busy      = (state_q != ST_IDLE);
  assign dbg_state = state_q;

endmodule
